// File: rtl/countdown_timer.sv
// Seconds countdown timer: a prescaler divides clk into seconds and a
// seconds counter runs down from a loaded value, optionally reloading on expiry.
module countdown_timer #(
  parameter int TICKS_PER_SEC = 10,
  parameter int CNT_WIDTH     = 32,
  parameter int SEC_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 sync_reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 load,
  input  logic [SEC_WIDTH-1:0] load_value,
  input  logic                 auto_reload,
  output logic                 second_elapsed,
  output logic                 half_second_elapsed,
  output logic [SEC_WIDTH-1:0] seconds_left,
  output logic                 running,
  output logic                 expired,
  output logic                 expire_pulse,
  output logic [1:0]           debug_state
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_EXPIRED = 2'd2;

  localparam logic [CNT_WIDTH-1:0] LAST_TICK = CNT_WIDTH'(TICKS_PER_SEC - 1);
  localparam logic [CNT_WIDTH-1:0] HALF_TICK = CNT_WIDTH'(TICKS_PER_SEC / 2 - 1);
  localparam logic [SEC_WIDTH-1:0] ONE_SEC   = SEC_WIDTH'(1);

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic [CNT_WIDTH-1:0] prescaler;
  logic [CNT_WIDTH-1:0] prescaler_next;
  logic [SEC_WIDTH-1:0] seconds_next;
  logic [SEC_WIDTH-1:0] reload_value;
  logic [SEC_WIDTH-1:0] reload_next;
  logic                 pulse_next;
  logic                 counting;
  logic                 at_last;
  logic                 at_half;

  // Strobes are combinational so they mark the last cycle of the counted
  // second itself; load, clear and reset all suppress counting.
  assign counting = (state == ST_RUNNING) && enable && !load && !clear && !sync_reset;
  assign at_last  = (prescaler == LAST_TICK);
  assign at_half  = (prescaler == HALF_TICK);

  assign second_elapsed      = counting && at_last;
  assign half_second_elapsed = counting && (at_last || at_half);
  assign running             = (state == ST_RUNNING);
  assign expired             = (state == ST_EXPIRED);
  assign debug_state         = state;

  always_comb begin
    state_next     = state;
    prescaler_next = prescaler;
    seconds_next   = seconds_left;
    reload_next    = reload_value;
    pulse_next     = 1'b0;
    if (load) begin
      prescaler_next = '0;
      if (load_value != '0) begin
        seconds_next = load_value;
        reload_next  = load_value;
        state_next   = ST_RUNNING;
      end else begin
        seconds_next = '0;
        state_next   = ST_IDLE;
      end
    end else if (clear) begin
      prescaler_next = '0;
    end else if (counting) begin
      if (at_last) begin
        prescaler_next = '0;
        if (seconds_left > ONE_SEC) begin
          seconds_next = seconds_left - ONE_SEC;
        end else if (seconds_left == ONE_SEC) begin
          // auto_reload is sampled only here, at the moment of expiry.
          pulse_next = 1'b1;
          if (auto_reload) begin
            seconds_next = reload_value;
          end else begin
            seconds_next = '0;
            state_next   = ST_EXPIRED;
          end
        end
      end else begin
        prescaler_next = prescaler + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state        <= ST_IDLE;
      prescaler    <= '0;
      seconds_left <= '0;
      reload_value <= '0;
      expire_pulse <= 1'b0;
    end else begin
      state        <= state_next;
      prescaler    <= prescaler_next;
      seconds_left <= seconds_next;
      reload_value <= reload_next;
      expire_pulse <= pulse_next;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random traffic, each
// cycle compared against a second/phase-based reference model.
module tb_countdown_timer;
  localparam int T  = 10;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          sync_reset = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          load = 1'b0;
  logic [SW-1:0] load_value = '0;
  logic          auto_reload = 1'b0;
  logic          second_elapsed, half_second_elapsed, running, expired, expire_pulse;
  logic [SW-1:0] seconds_left;
  logic [1:0]    debug_state;

  countdown_timer #(.TICKS_PER_SEC(T), .CNT_WIDTH(32), .SEC_WIDTH(SW)) dut (
    .clk(clk), .sync_reset(sync_reset), .enable(enable), .clear(clear),
    .load(load), .load_value(load_value), .auto_reload(auto_reload),
    .second_elapsed(second_elapsed), .half_second_elapsed(half_second_elapsed),
    .seconds_left(seconds_left), .running(running), .expired(expired),
    .expire_pulse(expire_pulse), .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  // Reference model: phase = cycles already counted in the current second.
  string m_mode = "idle";
  int    m_phase = 0;
  int    m_secs = 0;
  int    m_reload = 0;
  bit    m_pulse = 1'b0;

  int checks = 0;
  int fails = 0;
  bit saw_sec, saw_half, saw_exp;
  int exp_q[$];

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic drive(input bit rst, input bit en, input bit clr, input bit ld,
                       input int val, input bit ar);
    sync_reset  = rst;
    enable      = en;
    clear       = clr;
    load        = ld;
    load_value  = SW'(val);
    auto_reload = ar;
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then advance it.
  task automatic tick();
    bit cnt, e_sec, e_half;
    cnt    = (m_mode == "run") && enable && !load && !clear && !sync_reset;
    e_sec  = cnt && (m_phase == T - 1);
    e_half = cnt && (m_phase == T / 2 - 1 || m_phase == T - 1);
    @(negedge clk);
    check("second_elapsed", int'(second_elapsed), int'(e_sec));
    check("half_second_elapsed", int'(half_second_elapsed), int'(e_half));
    check("seconds_left", int'(seconds_left), m_secs);
    check("running", int'(running), int'(m_mode == "run"));
    check("expired", int'(expired), int'(m_mode == "exp"));
    check("expire_pulse", int'(expire_pulse), int'(m_pulse));
    saw_sec  = second_elapsed;
    saw_half = half_second_elapsed;
    saw_exp  = expire_pulse;
    @(posedge clk);
    m_pulse = 1'b0;
    if (sync_reset) begin
      m_mode = "idle"; m_phase = 0; m_secs = 0; m_reload = 0;
    end else if (load) begin
      m_phase = 0;
      if (int'(load_value) != 0) begin
        m_secs = int'(load_value); m_reload = int'(load_value); m_mode = "run";
      end else begin
        m_secs = 0; m_mode = "idle";
      end
    end else if (clear) begin
      m_phase = 0;
    end else if (cnt) begin
      m_phase = (m_phase + 1) % T;
      if (e_sec) begin
        if (m_secs > 1) m_secs--;
        else if (m_secs == 1) begin
          m_pulse = 1'b1;
          if (auto_reload) m_secs = m_reload;
          else begin m_secs = 0; m_mode = "exp"; end
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0);
    tick(); tick();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_load(input int val, input bit ar);
    drive(0, 1, 0, 1, val, ar);
    tick();
    drive(0, 1, 0, 0, 0, ar);
  endtask

  initial begin
    #1;
    // Reset state
    do_reset();
    tick();
    check("reset_state", int'(debug_state), 0);

    // Load 3, one-shot: strobes at cycles 10/20/30, expire pulse at 31
    do_load(3, 0);
    exp_q.delete();
    for (int k = 1; k <= 35; k++) begin
      tick();
      if (saw_sec) exp_q.push_back(k);
      if (saw_exp) check("load3_expire_cycle", k, 31);
    end
    check("load3_sec_count", exp_q.size(), 3);
    if (exp_q.size() == 3) begin
      check("load3_sec1", exp_q[0], 10);
      check("load3_sec2", exp_q[1], 20);
      check("load3_sec3", exp_q[2], 30);
    end
    check("load3_expired_held", int'(expired), 1);
    check("load3_zero", int'(seconds_left), 0);

    // Auto reload of 2: pulses every 20 cycles, running stays high
    do_load(2, 1);
    exp_q.delete();
    for (int k = 1; k <= 62; k++) begin
      tick();
      if (saw_exp) exp_q.push_back(k);
      if (!running) check("reload_running", 0, 1);
    end
    check("reload_pulses", exp_q.size(), 3);
    if (exp_q.size() == 3) begin
      check("reload_p1", exp_q[0], 21);
      check("reload_p3", exp_q[2], 61);
    end

    // Pause 4 cycles mid-second delays the strobe by 4
    do_load(5, 0);
    exp_q.delete();
    for (int k = 1; k <= 14; k++) begin
      if (k >= 7 && k <= 10) enable = 1'b0; else enable = 1'b1;
      tick();
      if (saw_half) exp_q.push_back(k);
      if (saw_sec) check("pause_sec_cycle", k, 14);
    end
    check("pause_half_count", exp_q.size(), 2);
    if (exp_q.size() == 2) begin
      check("pause_half1", exp_q[0], 5);
      check("pause_half2", exp_q[1], 14);
    end

    // Clear at prescaler 7: no strobe, next second 10 cycles later
    do_load(5, 0);
    for (int k = 1; k <= 7; k++) tick();
    clear = 1'b1;
    tick();
    check("clear_no_sec", int'(saw_sec), 0);
    clear = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (saw_sec) check("clear_next_sec", k, 10);
    end
    check("clear_secs", int'(seconds_left), 4);

    // load+clear together while running
    for (int k = 0; k < 3; k++) tick();
    drive(0, 1, 1, 1, 9, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0);
    tick();
    check("loadclr_secs", int'(seconds_left), 9);
    for (int k = 2; k <= 10; k++) begin
      tick();
      if (saw_sec) check("loadclr_sec_cycle", k, 10);
    end
    drive(0, 1, 1, 1, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0);
    tick();
    check("load0_idle", int'(debug_state), 0);
    check("load0_secs", int'(seconds_left), 0);

    // Reset at cycle 15 of a load-3 countdown
    do_load(3, 0);
    for (int k = 1; k <= 14; k++) tick();
    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (saw_exp || saw_sec) check("reset_abort_strobe", 1, 0);
    end
    check("reset_abort_secs", int'(seconds_left), 0);

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      sync_reset  = ($urandom_range(0, 199) == 0);
      load        = ($urandom_range(0, 29) == 0);
      load_value  = SW'($urandom_range(0, 4));
      clear       = ($urandom_range(0, 24) == 0);
      enable      = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) auto_reload = ~auto_reload;
      tick();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
